// File: rtl/seq_rec_mult16.sv
// Sequential 16x16 approximate recursive multiplier: one shared M8_4 core issues the
// LL, LH, HL and HH sub-products over four cycles into a 32-bit shift-accumulator.

// 2x2 approximate cell: exact except 3x3, which yields 7 so the product fits in 3 bits.
module m2_k (
   input  logic [1:0] x,
   input  logic [1:0] y,
   output logic [2:0] p
);

   always_comb begin
      p[0] = x[0] & y[0];
      p[1] = (x[1] & y[0]) | (x[0] & y[1]);
      p[2] = x[1] & y[1];
   end

endmodule

// 4x4 recursive multiplier built from four approximate 2x2 cells.
module m4_4 (
   input  logic [3:0] x,
   input  logic [3:0] y,
   output logic [7:0] p
);

   logic [2:0] p_ll;
   logic [2:0] p_lh;
   logic [2:0] p_hl;
   logic [2:0] p_hh;

   m2_k u_ll (.x(x[1:0]), .y(y[1:0]), .p(p_ll));
   m2_k u_lh (.x(x[1:0]), .y(y[3:2]), .p(p_lh));
   m2_k u_hl (.x(x[3:2]), .y(y[1:0]), .p(p_hl));
   m2_k u_hh (.x(x[3:2]), .y(y[3:2]), .p(p_hh));

   always_comb begin
      p = {5'b0, p_ll}
        + {3'b0, p_lh, 2'b0}
        + {3'b0, p_hl, 2'b0}
        + {1'b0, p_hh, 4'b0};
   end

endmodule

// M8_4: 8x8 recursive multiplier composed of four approximate 4x4 blocks.
module m8_4 (
   input  logic [7:0]  x,
   input  logic [7:0]  y,
   output logic [15:0] p
);

   logic [7:0] p_ll;
   logic [7:0] p_lh;
   logic [7:0] p_hl;
   logic [7:0] p_hh;

   m4_4 u_ll (.x(x[3:0]), .y(y[3:0]), .p(p_ll));
   m4_4 u_lh (.x(x[3:0]), .y(y[7:4]), .p(p_lh));
   m4_4 u_hl (.x(x[7:4]), .y(y[3:0]), .p(p_hl));
   m4_4 u_hh (.x(x[7:4]), .y(y[7:4]), .p(p_hh));

   always_comb begin
      p = {8'b0, p_ll}
        + {4'b0, p_lh, 4'b0}
        + {4'b0, p_hl, 4'b0}
        + {p_hh, 8'b0};
   end

endmodule

module seq_rec_mult16 #(
   parameter int EXACT_LL = 0,
   parameter int ACC_W    = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] Y,
   output logic        busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [1:0]       step_q, step_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [15:0]      a_q, a_d;
   logic [15:0]      b_q, b_d;
   logic [31:0]      y_q, y_d;

   logic [7:0]       op_x;
   logic [7:0]       op_y;
   logic [4:0]       shamt;
   logic [15:0]      prod_apx;
   logic [15:0]      prod_ll_exact;
   logic [15:0]      prod16;
   logic [ACC_W-1:0] term;
   logic [ACC_W-1:0] sum;

   // Operand steering for the shared core follows the step counter combinationally.
   always_comb begin
      op_x  = a_q[7:0];
      op_y  = b_q[7:0];
      shamt = 5'd0;
      case (step_q)
         2'd0: begin op_x = a_q[7:0];  op_y = b_q[7:0];  shamt = 5'd0;  end
         2'd1: begin op_x = a_q[7:0];  op_y = b_q[15:8]; shamt = 5'd8;  end
         2'd2: begin op_x = a_q[15:8]; op_y = b_q[7:0];  shamt = 5'd8;  end
         2'd3: begin op_x = a_q[15:8]; op_y = b_q[15:8]; shamt = 5'd16; end
         default: ;
      endcase
   end

   m8_4 u_core (.x(op_x), .y(op_y), .p(prod_apx));

   always_comb begin
      prod_ll_exact = 16'(a_q[7:0]) * 16'(b_q[7:0]);
      if (EXACT_LL != 0 && step_q == 2'd0) begin
         prod16 = prod_ll_exact;
      end else begin
         prod16 = prod_apx;
      end
      term = ACC_W'(prod16) << shamt;
      sum  = acc_q + term;
   end

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      acc_d   = acc_q;
      a_d     = a_q;
      b_d     = b_q;
      y_d     = y_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               acc_d   = '0;
               step_d  = 2'd0;
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            acc_d  = sum;
            step_d = step_q + 2'd1;
            if (step_q == 2'd3) begin
               y_d     = sum[31:0];
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         step_q  <= 2'd0;
         acc_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         acc_q   <= acc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         y_q     <= y_d;
      end
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
      busy      = (state_q != ST_IDLE);
      Y         = y_q;
   end

endmodule

// File: tb/tb_seq_rec_mult16.sv
// Directed and randomized checks of seq_rec_mult16 with both LL modes side by side.
module tb_seq_rec_mult16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        out_ready = 1'b1;

   logic        ir0, ov0, busy0;
   logic        ir1, ov1, busy1;
   logic [31:0] y0, y1;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   seq_rec_mult16 #(.EXACT_LL(0)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0),
      .a(a), .b(b), .out_valid(ov0), .out_ready(out_ready), .Y(y0), .busy(busy0)
   );

   seq_rec_mult16 #(.EXACT_LL(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
      .a(a), .b(b), .out_valid(ov1), .out_ready(out_ready), .Y(y1), .busy(busy1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Flat reference: sum of all 2-bit digit products, 3x3 digits giving 7.
   function automatic logic [31:0] gold(input logic [15:0] x, input logic [15:0] y, input bit ex);
      logic [31:0] s;
      logic [1:0]  dx;
      logic [1:0]  dy;
      logic [31:0] pp;
      s = '0;
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            if (!(ex && i < 4 && j < 4)) begin
               dx = x[2*i +: 2];
               dy = y[2*j +: 2];
               pp = (dx == 2'd3 && dy == 2'd3) ? 32'd7 : 32'(dx) * 32'(dy);
               s  = s + (pp << (2 * (i + j)));
            end
         end
      end
      if (ex) s = s + 32'(x[7:0]) * 32'(y[7:0]);
      return s;
   endfunction

   // Accepts one operand pair, waits for the result and checks latency, both Y values and
   // the single-cycle out_valid (out_ready is high throughout).
   task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                        input logic [31:0] e0, input logic [31:0] e1);
      int lat;
      in_valid = 1'b1;
      a = ta;
      b = tb_;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = ~ta;
      b = ~tb_;
      lat = 0;
      while (!ov0 && lat < 12) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_lat"}, 32'(lat), 32'd4);
      chk({tag, "_y0"}, y0, e0);
      chk({tag, "_y1"}, y1, e1);
      chk({tag, "_ov1"}, {31'b0, ov1}, 32'd1);
      @(posedge clk); #1;
      chk({tag, "_ovfall"}, {31'b0, ov0}, 32'd0);
      chk({tag, "_irdy"}, {31'b0, ir0}, 32'd1);
   endtask

   task automatic rnd_op(input logic [15:0] ta, input logic [15:0] tb_);
      int lat;
      in_valid = 1'b1;
      a = ta;
      b = tb_;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!ov0 && lat < 12) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("rnd_ov", {31'b0, ov0}, 32'd1);
      chk("rnd_y0", y0, gold(ta, tb_, 1'b0));
      chk("rnd_y1", y1, gold(ta, tb_, 1'b1));
      @(posedge clk); #1;
   endtask

   initial begin
      int lat;
      logic [15:0] ra;
      logic [15:0] rb;

      #1 rst = 1'b1;
      #1;
      chk("rst_irdy", {31'b0, ir0}, 32'd1);
      chk("rst_ov", {31'b0, ov0}, 32'd0);
      chk("rst_busy", {31'b0, busy0}, 32'd0);
      chk("rst_y", y0, 32'd0);
      #20 rst = 1'b0;
      @(posedge clk); #1;

      do_op("3x5", 16'h0003, 16'h0005, 32'h0000000F, 32'h0000000F);

      // Asynchronous reset in idle clears the held result before any edge.
      #2 rst = 1'b1;
      #1;
      chk("arst_irdy", {31'b0, ir0}, 32'd1);
      chk("arst_ov", {31'b0, ov0}, 32'd0);
      chk("arst_y", y0, 32'd0);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      do_op("100x100", 16'h0100, 16'h0100, 32'h00010000, 32'h00010000);
      do_op("0xffff", 16'h0000, 16'hFFFF, 32'h00000000, 32'h00000000);
      do_op("3x3", 16'h0003, 16'h0003, 32'h00000007, 32'h00000009);
      do_op("hl3x3", 16'h0300, 16'h0003, 32'h00000700, 32'h00000700);
      do_op("max", 16'hFFFF, 16'hFFFF, 32'hC71AE38F, 32'hC71B1C01);

      // Held result under back-pressure; in_valid pulses during DONE must not latch.
      out_ready = 1'b0;
      in_valid = 1'b1;
      a = 16'h0100;
      b = 16'h0100;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!ov0 && lat < 12) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("bp_lat", 32'(lat), 32'd4);
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         a = 16'h0005;
         b = 16'h0007;
         @(posedge clk); #1;
         chk("bp_ov", {31'b0, ov0}, 32'd1);
         chk("bp_irdy", {31'b0, ir0}, 32'd0);
         chk("bp_y", y0, 32'h00010000);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_ovfall", {31'b0, ov0}, 32'd0);
      chk("bp_busy", {31'b0, busy0}, 32'd0);
      chk("bp_yhold", y0, 32'h00010000);

      // Reset during step 2 of a max-operand product.
      in_valid = 1'b1;
      a = 16'hFFFF;
      b = 16'hFFFF;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #1 rst = 1'b1;
      #1;
      chk("mid_busy", {31'b0, busy0}, 32'd0);
      chk("mid_ov", {31'b0, ov0}, 32'd0);
      chk("mid_irdy", {31'b0, ir0}, 32'd1);
      chk("mid_y0", y0, 32'd0);
      chk("mid_y1", y1, 32'd0);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      do_op("2x3", 16'h0002, 16'h0003, 32'h00000006, 32'h00000006);

      for (int i = 0; i < 2000; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rnd_op(ra, rb);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
